// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus strobe FSM that feeds simple_alu one command at a time
// and returns each captured ALU result over a valid/ready channel.
module alu_cmd_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [3:0]                 cmd_a,
    input  logic [3:0]                 cmd_b,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [3:0]                 res_data,
    output logic [1:0]                 res_op,
    output logic                       alu_en_i,
    output logic                       alu_en_o,
    output logic [1:0]                 alu_select_op,
    output logic [3:0]                 alu_a,
    output logic [3:0]                 alu_b,
    input  logic [3:0]                 alu_out,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);
    // WAIT counts down to zero, so it is loaded with one less than the idle length
    localparam logic [2:0] WaitInit = (ALU_LAT > 0) ? 3'(ALU_LAT - 1) : 3'd0;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StRead,
        StResp
    } state_e;

    state_e          state_q;
    logic [2:0]      wait_q;
    logic [9:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push;
    logic            pop;

    assign cmd_ready  = (count_q != Full);
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state_q == StIdle) && (count_q != '0);
    assign fifo_count = count_q;
    assign busy       = (state_q != StIdle) || (count_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            wait_q        <= '0;
            alu_en_i      <= 1'b0;
            alu_en_o      <= 1'b0;
            alu_select_op <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            res_valid     <= 1'b0;
            res_data      <= '0;
            res_op        <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        {alu_select_op, alu_a, alu_b} <= mem_q[rd_ptr_q];
                        alu_en_i <= 1'b1;
                        state_q  <= StIssue;
                    end
                end
                StIssue: begin
                    alu_en_i <= 1'b0;
                    if (ALU_LAT > 0) begin
                        wait_q  <= WaitInit;
                        state_q <= StWait;
                    end else begin
                        alu_en_o <= 1'b1;
                        state_q  <= StRead;
                    end
                end
                StWait: begin
                    if (wait_q == '0) begin
                        alu_en_o <= 1'b1;
                        state_q  <= StRead;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                StRead: begin
                    alu_en_o  <= 1'b0;
                    res_data  <= alu_out;
                    res_op    <= alu_select_op;
                    res_valid <= 1'b1;
                    state_q   <= StResp;
                end
                StResp: begin
                    if (res_ready) begin
                        res_valid     <= 1'b0;
                        alu_select_op <= '0;
                        alu_a         <= '0;
                        alu_b         <= '0;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: a behavioural ALU answers the strobes,
// expected results are queued at push time and compared as results are accepted.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_a, cmd_b;
    logic       res_valid, res_ready;
    logic [3:0] res_data;
    logic [1:0] res_op;
    logic       alu_en_i, alu_en_o;
    logic [1:0] alu_select_op;
    logic [3:0] alu_a, alu_b, alu_out;
    logic       busy;
    logic [2:0] fifo_count;

    // index 0: ALU_LAT=0, index 1: ALU_LAT=7
    logic       l_cmd_valid [2];
    logic       l_cmd_ready [2];
    logic [1:0] l_cmd_op    [2];
    logic [3:0] l_cmd_a     [2];
    logic [3:0] l_cmd_b     [2];
    logic       l_res_valid [2];
    logic       l_res_ready [2];
    logic [3:0] l_res_data  [2];
    logic [1:0] l_res_op    [2];
    logic       l_en_i      [2];
    logic       l_en_o      [2];
    logic [1:0] l_sel       [2];
    logic [3:0] l_a         [2];
    logic [3:0] l_b         [2];
    logic [3:0] l_out       [2];
    logic       l_busy      [2];
    logic [2:0] l_count     [2];

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    // Outside en_o the ALU drives the complement, so a mistimed capture shows up
    assign alu_out  = alu_en_o ? alu_f(alu_select_op, alu_a, alu_b)
                               : ~alu_f(alu_select_op, alu_a, alu_b);
    assign l_out[0] = l_en_o[0] ? alu_f(l_sel[0], l_a[0], l_b[0]) : ~alu_f(l_sel[0], l_a[0], l_b[0]);
    assign l_out[1] = l_en_o[1] ? alu_f(l_sel[1], l_a[1], l_b[1]) : ~alu_f(l_sel[1], l_a[1], l_b[1]);

    alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_op(res_op), .alu_en_i(alu_en_i),
        .alu_en_o(alu_en_o), .alu_select_op(alu_select_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .busy(busy), .fifo_count(fifo_count)
    );

    alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(l_cmd_valid[0]), .cmd_ready(l_cmd_ready[0]),
        .cmd_op(l_cmd_op[0]), .cmd_a(l_cmd_a[0]), .cmd_b(l_cmd_b[0]),
        .res_valid(l_res_valid[0]), .res_ready(l_res_ready[0]), .res_data(l_res_data[0]),
        .res_op(l_res_op[0]), .alu_en_i(l_en_i[0]), .alu_en_o(l_en_o[0]),
        .alu_select_op(l_sel[0]), .alu_a(l_a[0]), .alu_b(l_b[0]), .alu_out(l_out[0]),
        .busy(l_busy[0]), .fifo_count(l_count[0])
    );

    alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(7)) u_lat7 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(l_cmd_valid[1]), .cmd_ready(l_cmd_ready[1]),
        .cmd_op(l_cmd_op[1]), .cmd_a(l_cmd_a[1]), .cmd_b(l_cmd_b[1]),
        .res_valid(l_res_valid[1]), .res_ready(l_res_ready[1]), .res_data(l_res_data[1]),
        .res_op(l_res_op[1]), .alu_en_i(l_en_i[1]), .alu_en_o(l_en_o[1]),
        .alu_select_op(l_sel[1]), .alu_a(l_a[1]), .alu_b(l_b[1]), .alu_out(l_out[1]),
        .busy(l_busy[1]), .fifo_count(l_count[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic rdy;
        int   n;
        exp_t e;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        n = 0;
        do begin
            rdy = cmd_ready;
            step();
            n++;
        end while (!rdy && n < 50);
        check("push_accept", rdy, 1);
        if (rdy) begin
            e.op = op; e.a = a; e.b = b; e.data = alu_f(op, a, b);
            sb.push_back(e);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max) begin
            step();
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic measure(input int k, input int lat);
        int n;
        l_cmd_op[k] = 2'b10; l_cmd_a[k] = 4'hC; l_cmd_b[k] = 4'hA;
        l_cmd_valid[k] = 1'b1;
        step();
        l_cmd_valid[k] = 1'b0;
        step();
        check("lat_en_i", l_en_i[k], 1);
        n = 0;
        step();
        while (!l_en_o[k] && n < 20) begin
            check("lat_idle_en_i", l_en_i[k], 0);
            step();
            n++;
        end
        check("lat_gap", n, lat);
        check("lat_no_overlap", l_en_i[k], 0);
        step();
        check("lat_en_o_1cyc", l_en_o[k], 0);
        check("lat_res_valid", l_res_valid[k], 1);
        check("lat_res_data", l_res_data[k], alu_f(2'b10, 4'hC, 4'hA));
        check("lat_res_op", l_res_op[k], 2'b10);
    endtask

    // Strobe and result monitor, sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (alu_en_i || alu_en_o) check("overlap", alu_en_i & alu_en_o, 0);
            if (alu_en_o) begin
                if (sb.size() == 0) begin
                    check("en_o_without_cmd", 1, 0);
                end else begin
                    check("strobe_op", alu_select_op, sb[0].op);
                    check("strobe_a", alu_a, sb[0].a);
                    check("strobe_b", alu_b, sb[0].b);
                end
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("res_data", res_data, e.data);
                    check("res_op", res_op, e.op);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            l_cmd_valid[k] = 1'b0; l_cmd_op[k] = '0; l_cmd_a[k] = '0; l_cmd_b[k] = '0;
            l_res_ready[k] = 1'b1;
        end
        step();
        step();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_strobes", {alu_en_i, alu_en_o, res_valid}, 0);
        check("rst_buses", {alu_select_op, alu_a, alu_b, res_data, res_op}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single command, ALU_LAT=1
        res_ready = 1'b1;
        push(2'b00, 4'd1, 4'd3);
        check("t1_count_e0", fifo_count, 1);
        check("t1_en_i_e0", alu_en_i, 0);
        step();
        check("t1_en_i_e1", alu_en_i, 1);
        check("t1_a_e1", {alu_a, alu_b}, {4'd1, 4'd3});
        check("t1_count_e1", fifo_count, 0);
        step();
        check("t1_wait", {alu_en_i, alu_en_o}, 0);
        step();
        check("t1_en_o_e3", {alu_en_i, alu_en_o}, 2'b01);
        check("t1_ab_e3", {alu_a, alu_b}, {4'd1, 4'd3});
        check("t1_no_res_e3", res_valid, 0);
        step();
        check("t1_res_valid_e4", res_valid, 1);
        check("t1_res_data", res_data, 4'd4);
        check("t1_res_op", res_op, 2'b00);
        step();
        check("t1_res_done", res_valid, 0);
        check("t1_idle", busy, 0);
        check("t1_ab_cleared", {alu_select_op, alu_a, alu_b}, 0);

        // Five back-to-back commands with the consumer stalled
        res_ready = 1'b0;
        push(2'b00, 4'd2, 4'd5);
        push(2'b01, 4'd9, 4'd3);
        push(2'b10, 4'd6, 4'd12);
        push(2'b11, 4'd5, 4'd10);
        push(2'b00, 4'd15, 4'd15);
        check("t2_full_ready", cmd_ready, 0);
        check("t2_full_count", fifo_count, 4);
        repeat (10) step();
        check("t2_hold_valid", res_valid, 1);
        check("t2_hold_data", res_data, sb[0].data);
        check("t2_hold_op", res_op, sb[0].op);
        cmd_op = 2'b01; cmd_a = 4'd7; cmd_b = 4'd7; cmd_valid = 1'b1;
        repeat (3) step();
        cmd_valid = 1'b0;
        check("t2_refused", fifo_count, 4);

        // Release the consumer and drain in order
        res_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (!cmd_ready && n < 10) begin
                step();
                n++;
            end
        end
        check("t3_ready_back", cmd_ready, 1);
        check("t3_count_after_pop", fifo_count, 3);
        wait_drain(100);
        step();
        check("t3_idle", busy, 0);

        // Push on the very edge that pops, with two entries queued
        res_ready = 1'b0;
        push(2'b01, 4'd4, 4'd7);
        push(2'b10, 4'd3, 4'd3);
        push(2'b11, 4'd8, 4'd1);
        begin
            int n;
            n = 0;
            while (!res_valid && n < 20) begin
                step();
                n++;
            end
        end
        check("t6_in_resp", res_valid, 1);
        check("t6_count2", fifo_count, 2);
        res_ready = 1'b1;
        step();
        check("t6_back_idle", res_valid, 0);
        push(2'b00, 4'd11, 4'd2);
        check("t6_count_kept", fifo_count, 2);
        check("t6_popped", alu_en_i, 1);
        wait_drain(100);

        // Asynchronous reset while waiting on the ALU with two commands queued
        step();
        push(2'b01, 4'd1, 4'd1);
        push(2'b10, 4'd2, 4'd2);
        push(2'b11, 4'd3, 4'd3);
        check("t5_pre_count", fifo_count, 2);
        check("t5_pre_wait", {alu_en_i, alu_en_o, res_valid}, 0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("t5_count", fifo_count, 0);
        check("t5_ready", cmd_ready, 1);
        check("t5_outputs", {busy, alu_en_i, alu_en_o, res_valid, alu_select_op, alu_a, alu_b,
                             res_data, res_op}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) step();
        check("t5_no_result", res_valid, 0);
        check("t5_still_idle", {busy, fifo_count}, 0);

        // Strobe spacing at the latency extremes
        measure(0, 0);
        measure(1, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
